// File: rtl/rst_gen_pkg.sv
// Shared types and default parameter values for the switch reset generator.
package rst_gen_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_GUARD  = 2'd1,
        ST_RUN    = 2'd2
    } rst_state_e;

    localparam int DEF_ASSERT_CYCLES = 16;
    localparam int DEF_GUARD_CYCLES  = 4;
    localparam int DEF_DEBOUNCE      = 3;
    localparam int DEF_CNT_W         = 8;
    localparam int DEF_EVT_W         = 16;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rst_req_debounce.sv
// Qualifies the synchronised external reset request: one pulse per run of
// DEBOUNCE consecutive high samples; a low sample re-arms it.
module rst_req_debounce
    import rst_gen_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ext_req,
    output logic o_ext_qual
);

    localparam int DW = cnt_width(DEBOUNCE);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

    logic [DW-1:0] r_cnt;
    logic          r_qual;

    // Run-length counter saturates at DEBOUNCE so a long high level fires once.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= {DW{1'b0}};
            r_qual <= 1'b0;
        end else if (!i_ext_req) begin
            r_cnt  <= {DW{1'b0}};
            r_qual <= 1'b0;
        end else begin
            if (r_cnt != DB_MAX) begin
                r_cnt <= r_cnt + DW'(1);
            end else begin
                r_cnt <= r_cnt;
            end
            r_qual <= (r_cnt == DB_LAST);
        end
    end

    assign o_ext_qual = r_qual;

endmodule

// File: rtl/rst_n_gen.sv
// Reset generator: power-on and on-request reset sequences driving a
// registered active-low reset, with busy/done status and an event counter.
module rst_n_gen
    import rst_gen_pkg::*;
#(
    parameter int ASSERT_CYCLES = DEF_ASSERT_CYCLES,
    parameter int GUARD_CYCLES  = DEF_GUARD_CYCLES,
    parameter int DEBOUNCE      = DEF_DEBOUNCE,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int EVT_W         = DEF_EVT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sw_req,
    input  logic             i_ext_req,
    input  logic [CNT_W-1:0] i_hold_len,
    output logic             o_rst_n,
    output logic             o_busy,
    output logic             o_rst_done,
    output logic [EVT_W-1:0] o_rst_events
);

    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] DEF_HOLD   = CNT_W'(ASSERT_CYCLES);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [EVT_W-1:0] EVT_MAX    = {EVT_W{1'b1}};

    rst_state_e       r_state;
    rst_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] w_hold_nxt;
    logic [CNT_W-1:0] w_hold_sel;
    logic             r_rst_n;
    logic             w_rst_n_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [EVT_W-1:0] r_events;
    logic [EVT_W-1:0] w_events_nxt;
    logic             w_ext_qual;
    logic             w_req;

    rst_req_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ext_req  (i_ext_req),
        .o_ext_qual (w_ext_qual)
    );

    // Both sources merge into one request, so coincident requests start one sequence.
    assign w_req      = i_sw_req | w_ext_qual;
    assign w_hold_sel = (i_hold_len != C_ZERO) ? i_hold_len : DEF_HOLD;

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_ASSERT;
            r_cnt    <= C_ZERO;
            r_hold   <= DEF_HOLD;
            r_rst_n  <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_events <= {EVT_W{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hold   <= w_hold_nxt;
            r_rst_n  <= w_rst_n_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_events <= w_events_nxt;
        end
    end

    // Next state: a request restarts the sequence from any state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ASSERT: begin
                if (w_req) begin
                    w_state_nxt = ST_ASSERT;
                end else if (r_cnt == r_hold - C_ONE) begin
                    w_state_nxt = ST_GUARD;
                end else begin
                    w_state_nxt = ST_ASSERT;
                end
            end
            ST_GUARD: begin
                if (w_req) begin
                    w_state_nxt = ST_ASSERT;
                end else if (r_cnt == GUARD_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_GUARD;
                end
            end
            ST_RUN: begin
                if (w_req) begin
                    w_state_nxt = ST_ASSERT;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_ASSERT;
            end
        endcase
    end

    // Next values of counter, hold length and the registered outputs.
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_hold_nxt   = r_hold;
        w_events_nxt = r_events;
        if (w_req || (w_state_nxt != r_state) || (r_state == ST_RUN)) begin
            w_cnt_nxt = C_ZERO;
        end else begin
            w_cnt_nxt = r_cnt + C_ONE;
        end
        if (w_req) begin
            w_hold_nxt = w_hold_sel;
        end else begin
            w_hold_nxt = r_hold;
        end
        w_rst_n_nxt = (w_state_nxt != ST_ASSERT);
        w_busy_nxt  = (w_state_nxt != ST_RUN);
        w_done_nxt  = (r_state == ST_GUARD) && (w_state_nxt == ST_RUN);
        if (w_done_nxt && (r_events != EVT_MAX)) begin
            w_events_nxt = r_events + EVT_W'(1);
        end else begin
            w_events_nxt = r_events;
        end
    end

    assign o_rst_n      = r_rst_n;
    assign o_busy       = r_busy;
    assign o_rst_done   = r_done;
    assign o_rst_events = r_events;

endmodule
